// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - data-memory load/store unit with byte-lane encoding, load extension and timeout
module dmem_lsu #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 64,
    parameter int CNT_WIDTH  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic                  dmem_sel,
    input  logic [1:0]            w_sel,
    input  logic [2:0]            r_sel,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic                  done,
    output logic [31:0]           rdata,
    output logic                  err_misalign,
    output logic                  err_timeout,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-3:0] maddr_q, maddr_d;
    logic [3:0]            be_q, be_d;
    logic [31:0]           mwdata_q, mwdata_d;
    logic [2:0]            rsel_q, rsel_d;
    logic [1:0]            off_q, off_d;
    logic                  done_q, done_d;
    logic                  err_mis_q, err_mis_d;
    logic                  err_to_q, err_to_d;
    logic [31:0]           rdata_q, rdata_d;

    logic        is_store, is_load, is_half, is_word, misalign;
    logic [3:0]  be_enc;
    logic [31:0] wdata_enc;
    logic [31:0] load_ext;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Decode of the incoming operation; store takes priority over load.
    always_comb begin
        is_store = dmem_sel && (w_sel != 2'b11);
        is_load  = !dmem_sel && ((r_sel == 3'b000) || (r_sel == 3'b010) || (r_sel == 3'b011) ||
                                 (r_sel == 3'b100) || (r_sel == 3'b101));
        is_half  = is_store ? (w_sel == 2'b01) : ((r_sel == 3'b010) || (r_sel == 3'b101));
        is_word  = is_store ? (w_sel == 2'b10) : (r_sel == 3'b011);
        misalign = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
        be_enc    = 4'b1111;
        wdata_enc = wdata;
        if (is_store) begin
            case (w_sel)
                2'b00: begin
                    be_enc    = 4'b0001 << addr[1:0];
                    wdata_enc = {4{wdata[7:0]}};
                end
                2'b01: begin
                    be_enc    = addr[1] ? 4'b1100 : 4'b0011;
                    wdata_enc = {2{wdata[15:0]}};
                end
                default: begin
                    be_enc    = 4'b1111;
                    wdata_enc = wdata;
                end
            endcase
        end
    end

    // Lane extraction from the returned word using the latched byte offset.
    always_comb begin
        ld_byte = mem_rdata[8*off_q +: 8];
        ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (rsel_q)
            3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  load_ext = {24'd0, ld_byte};
            3'b010:  load_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  load_ext = {16'd0, ld_half};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        maddr_d   = maddr_q;
        be_d      = be_q;
        mwdata_d  = mwdata_q;
        rsel_d    = rsel_q;
        off_d     = off_q;
        done_d    = 1'b0;
        err_mis_d = 1'b0;
        err_to_d  = 1'b0;
        rdata_d   = 32'd0;
        case (state_q)
            S_IDLE: begin
                if (op_valid && (is_store || is_load)) begin
                    if (misalign) begin
                        state_d   = S_RESP;
                        err_mis_d = 1'b1;
                    end else begin
                        state_d  = S_ACCESS;
                        cnt_d    = '0;
                        we_d     = is_store;
                        maddr_d  = addr[ADDR_WIDTH-1:2];
                        be_d     = be_enc;
                        mwdata_d = wdata_enc;
                        rsel_d   = r_sel;
                        off_d    = addr[1:0];
                    end
                end
            end
            S_ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                // A response on the last allowed cycle still counts as success.
                if (mem_ready) begin
                    state_d = S_RESP;
                    done_d  = 1'b1;
                    rdata_d = we_q ? 32'd0 : load_ext;
                end else if (cnt_q == CNT_WIDTH'(TIMEOUT - 1)) begin
                    state_d  = S_RESP;
                    err_to_d = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            maddr_q   <= '0;
            be_q      <= 4'b0000;
            mwdata_q  <= 32'd0;
            rsel_q    <= 3'b111;
            off_q     <= 2'b00;
            done_q    <= 1'b0;
            err_mis_q <= 1'b0;
            err_to_q  <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            maddr_q   <= maddr_d;
            be_q      <= be_d;
            mwdata_q  <= mwdata_d;
            rsel_q    <= rsel_d;
            off_q     <= off_d;
            done_q    <= done_d;
            err_mis_q <= err_mis_d;
            err_to_q  <= err_to_d;
            rdata_q   <= rdata_d;
        end
    end

    assign op_ready     = (state_q == S_IDLE);
    assign mem_req      = (state_q == S_ACCESS);
    assign mem_we       = we_q;
    assign mem_addr     = maddr_q;
    assign mem_be       = be_q;
    assign mem_wdata    = mwdata_q;
    assign done         = done_q;
    assign rdata        = rdata_q;
    assign err_misalign = err_mis_q;
    assign err_timeout  = err_to_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - directed self-checking bench for dmem_lsu
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic        dmem_sel = 1'b0;
    logic [1:0]  w_sel = 2'b11;
    logic [2:0]  r_sel = 3'b111;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        done;
    logic [31:0] rdata;
    logic        err_misalign;
    logic        err_timeout;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ready = 1'b0;

    int checks = 0;
    int failures = 0;
    int req_cycles;

    dmem_lsu #(.ADDR_WIDTH(32), .TIMEOUT(64), .CNT_WIDTH(7)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .dmem_sel(dmem_sel), .w_sel(w_sel), .r_sel(r_sel), .addr(addr), .wdata(wdata),
        .done(done), .rdata(rdata), .err_misalign(err_misalign), .err_timeout(err_timeout),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one operation for a single accept edge; returns #1 after that edge.
    task automatic issue(input logic ds, input logic [1:0] ws, input logic [2:0] rs,
                         input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        op_valid = 1'b1; dmem_sel = ds; w_sel = ws; r_sel = rs; addr = a; wdata = wd;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    // Wait n cycles in ACCESS, then answer; returns #1 into RESP.
    task automatic respond(input int n, input logic [31:0] d);
        repeat (n) @(posedge clk);
        @(negedge clk);
        mem_ready = 1'b1; mem_rdata = d;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
    endtask

    task automatic load_case(input string tag, input logic [2:0] rs, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] exp);
        issue(1'b0, 2'b11, rs, a, 32'd0);
        check({tag, "_req"}, {31'd0, mem_req}, 32'd1);
        respond(1, d);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_rdata"}, rdata, exp);
        @(posedge clk); #1;
    endtask

    task automatic store_case(input string tag, input logic [1:0] ws, input logic [31:0] a,
                              input logic [31:0] wd, input logic [3:0] be, input logic [31:0] mwd);
        issue(1'b1, ws, 3'b111, a, wd);
        check({tag, "_we"}, {31'd0, mem_we}, 32'd1);
        check({tag, "_addr"}, {2'b00, mem_addr}, a >> 2);
        check({tag, "_be"}, {28'd0, mem_be}, {28'd0, be});
        check({tag, "_wdata"}, mem_wdata, mwd);
        respond(0, 32'hFFFF_FFFF);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_rdata0"}, rdata, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #12;
        check("rst_op_ready", {31'd0, op_ready}, 32'd1);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_be", {28'd0, mem_be}, 32'd0);
        check("rst_outs", {28'd0, done, err_misalign, err_timeout, mem_we}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // LW with three wait cycles
        issue(1'b0, 2'b11, 3'b011, 32'h0000_0010, 32'd0);
        check("lw_req", {31'd0, mem_req}, 32'd1);
        check("lw_ready_low", {31'd0, op_ready}, 32'd0);
        check("lw_addr", {2'b00, mem_addr}, 32'h4);
        check("lw_be", {28'd0, mem_be}, 32'hF);
        check("lw_we", {31'd0, mem_we}, 32'd0);
        respond(3, 32'hDEAD_BEEF);
        check("lw_done", {31'd0, done}, 32'd1);
        check("lw_rdata", rdata, 32'hDEAD_BEEF);
        check("lw_err", {30'd0, err_misalign, err_timeout}, 32'd0);
        check("lw_req_off", {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;
        check("lw_idle", {31'd0, op_ready}, 32'd1);
        check("lw_done_clr", {31'd0, done}, 32'd0);
        check("lw_rdata_clr", rdata, 32'd0);

        load_case("lb", 3'b000, 32'h0000_0013, 32'h80FF_1234, 32'hFFFF_FF80);
        load_case("lbu", 3'b100, 32'h0000_0013, 32'h80FF_1234, 32'h0000_0080);
        load_case("lh", 3'b010, 32'h0000_0012, 32'h80FF_1234, 32'hFFFF_80FF);
        load_case("lhu", 3'b101, 32'h0000_0012, 32'h80FF_1234, 32'h0000_80FF);
        load_case("lb0", 3'b000, 32'h0000_0010, 32'h80FF_1234, 32'h0000_0034);

        store_case("sb", 2'b00, 32'h0000_0021, 32'h0000_00AB, 4'b0010, 32'hABAB_ABAB);
        store_case("sh", 2'b01, 32'h0000_0022, 32'h0000_1234, 4'b1100, 32'h1234_1234);
        store_case("sw", 2'b10, 32'h0000_0024, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

        // Misaligned SH and LW
        issue(1'b1, 2'b01, 3'b111, 32'h0000_0003, 32'h1234);
        check("sh_mis_err", {31'd0, err_misalign}, 32'd1);
        check("sh_mis_req", {31'd0, mem_req}, 32'd0);
        check("sh_mis_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        check("sh_mis_clr", {31'd0, err_misalign}, 32'd0);
        check("sh_mis_idle", {31'd0, op_ready}, 32'd1);
        issue(1'b0, 2'b11, 3'b011, 32'h0000_0002, 32'd0);
        check("lw_mis_err", {31'd0, err_misalign}, 32'd1);
        check("lw_mis_req", {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;

        // Timeout: count cycles with mem_req high
        issue(1'b1, 2'b10, 3'b111, 32'h0000_0040, 32'h5555_AAAA);
        req_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            if (!mem_req) break;
            req_cycles++;
            @(posedge clk); #1;
        end
        check("to_req_cycles", req_cycles, 32'd64);
        check("to_err", {31'd0, err_timeout}, 32'd1);
        check("to_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        check("to_err_clr", {31'd0, err_timeout}, 32'd0);

        // Response on the final allowed cycle wins over timeout
        issue(1'b1, 2'b10, 3'b111, 32'h0000_0040, 32'h5555_AAAA);
        respond(63, 32'd0);
        check("last_done", {31'd0, done}, 32'd1);
        check("last_err", {31'd0, err_timeout}, 32'd0);
        @(posedge clk); #1;

        // Reset in the middle of ACCESS
        issue(1'b0, 2'b11, 3'b011, 32'h0000_0080, 32'd0);
        check("rstm_req_before", {31'd0, mem_req}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rstm_req", {31'd0, mem_req}, 32'd0);
        check("rstm_ready", {31'd0, op_ready}, 32'd1);
        check("rstm_pulses", {30'd0, done, err_timeout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rstm_after", {29'd0, done, err_timeout, err_misalign}, 32'd0);

        // No-op is accepted without a memory access
        issue(1'b0, 2'b11, 3'b111, 32'h0000_0100, 32'd0);
        check("noop_req", {31'd0, mem_req}, 32'd0);
        check("noop_ready", {31'd0, op_ready}, 32'd1);
        @(posedge clk); #1;
        check("noop_pulses", {29'd0, done, err_timeout, err_misalign}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Data-memory load/store unit at the writeback-side memory interface.
- Consumes the decoded memory controls (dmem_sel, w_sel, r_sel) plus an effective address and store data. Drives a variable-latency word-addressed data memory with byte enables.
- Returns sign- or zero-extended load data to the register writeback path.
- Provides a valid/ready handshake toward the pipeline, and misalignment and timeout error reporting.

Parameters:
ADDR_WIDTH, 32, byte address width; mem_addr is ADDR_WIDTH-2 bits (word address)
TIMEOUT, 64, max cycles in ACCESS waiting for mem_ready before abort (>=2)
CNT_WIDTH, 7, width of the timeout counter; must hold TIMEOUT

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
op_valid  in  1  operation request from pipeline
op_ready  out  1  unit can accept an operation (IDLE only)
dmem_sel  in  1  1=store, 0=load/none
w_sel  in  2  store width: 00 byte, 01 half, 10 word, 11 no store
r_sel  in  3  load type: 000 LB, 010 LH, 011 LW, 100 LBU, 101 LHU, 111 no load; others illegal
addr  in  ADDR_WIDTH  effective byte address
wdata  in  32  store data (low bits significant per width)
done  out  1  one-cycle pulse: operation completed successfully
rdata  out  32  extended load data, valid while done=1 for a load
err_misalign  out  1  one-cycle pulse: operation rejected for misalignment
err_timeout  out  1  one-cycle pulse: memory did not respond within TIMEOUT
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  1=write
mem_addr  out  ADDR_WIDTH-2  word address = addr[ADDR_WIDTH-1:2]
mem_be  out  4  byte enables for writes; 1111 for reads
mem_wdata  out  32  lane-replicated store data
mem_rdata  in  32  read data, valid when mem_ready=1
mem_ready  in  1  memory completion for current request

Behaviour:
- Reset (async, immediate):
  - State=IDLE; op_ready=1.
  - done, err_misalign, err_timeout, mem_req, mem_we = 0.
  - rdata, mem_addr, mem_wdata = 0; mem_be=0000; timeout counter=0.
  - Reset mid-ACCESS drops mem_req immediately; no done or error is produced.
- States: IDLE, ACCESS, RESP.
- Accept: op_valid & op_ready at a rising edge. Operands are latched and stay stable until the next IDLE.
- Classification, in priority order:
  - store if dmem_sel=1 and w_sel!=11;
  - load if dmem_sel=0 and r_sel in {000,010,011,100,101};
  - otherwise no-op.
  - A no-op is accepted, produces no memory access and no pulses, and the state stays IDLE.
- Misalignment:
  - Half access (SH, LH, LHU) with addr[0]=1 is misaligned.
  - Word access (SW, LW) with addr[1:0]!=00 is misaligned.
  - On accept: IDLE->RESP, err_misalign=1 during RESP, no mem_req.
- Aligned access: IDLE->ACCESS. From the cycle after accept, mem_req=1 and mem_we/mem_addr/mem_be/mem_wdata are registered and stable.
- Store encoding:
  - SB: be = 0001<<addr[1:0], mem_wdata = {4{wdata[7:0]}}.
  - SH: be = 0011<<(2*addr[1]), mem_wdata = {2{wdata[15:0]}}.
  - SW: be = 1111, mem_wdata = wdata.
- Loads: mem_we=0, be=1111.
- ACCESS:
  - The counter increments each cycle.
  - mem_ready=1 -> RESP with done=1. For a load, rdata = extracted lane: byte lane addr[1:0], half lane addr[1]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
  - Counter reaching TIMEOUT-1 without mem_ready -> RESP with err_timeout=1.
  - mem_ready in the same cycle as timeout expiry: mem_ready wins (done, no error).
  - mem_req deasserts on leaving ACCESS.
- RESP: exactly one cycle, then IDLE.
  - done, err_* and rdata are registered outputs valid only in RESP.
  - rdata=0 for stores and errors; done, err_* are 0 in all other states.
- Latency: accept at edge N, mem_req high from N+1, mem_ready sampled at edge M, done in cycle M+1, op_ready high again at M+2.
  - Minimum load-to-load spacing is 3 cycles.
  - op_valid while op_ready=0 is ignored; the pipeline must hold it.
- mem_ready outside ACCESS is ignored.

Test Plan:
- LW addr=0x0000_0010, memory returns 0xDEADBEEF after 3 wait cycles -> mem_addr=0x4, mem_be=1111, done=1, rdata=0xDEADBEEF, no errors.
- LB and LBU at addr=0x0000_0013, mem_rdata=0x80FF_1234 -> LB rdata=0xFFFF_FF80, LBU rdata=0x0000_0080; LH at 0x12 -> 0xFFFF_80FF, LHU -> 0x0000_80FF.
- SB addr=0x21 wdata=0x0000_00AB -> mem_we=1, mem_be=0010, mem_wdata=0xABAB_ABAB; SH addr=0x22 wdata=0x1234 -> be=1100, mem_wdata=0x1234_1234; SW addr=0x24 -> be=1111.
- SH addr=0x03 and LW addr=0x02 -> err_misalign pulse one cycle after accept, mem_req never asserted, done=0.
- Store with mem_ready held 0, TIMEOUT=64 -> mem_req high 64 cycles then drops, err_timeout=1; repeat with mem_ready asserted exactly on the final cycle -> done=1, err_timeout=0.
- Reset asserted while in ACCESS -> mem_req=0 and op_ready=1 immediately, no done/err; no-op (dmem_sel=0, r_sel=111) -> no mem_req, op_ready stays 1.
